// File: rtl/decoder_result_streamer_pkg.sv
// Shared definitions for decoder_result_streamer: geometry derivation,
// stream word width, HDR1 field offsets and the streaming FSM state type.
// The HDR1 offsets are also what host readout software decodes against.
package decoder_result_streamer_pkg;

  localparam int OUT_WIDTH = 32;

  // HDR1 word layout: {iteration[7:0], deadlock, final_cardinality, 6'b0, drop[7:0], 8'h00}
  localparam int HDR1_ITER_LSB       = 24;
  localparam int HDR1_DEADLOCK_BIT   = 23;
  localparam int HDR1_FINAL_CARD_BIT = 22;
  localparam int HDR1_DROP_LSB       = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_ROOTS = 3'd3,
    ST_TRL   = 3'd4
  } stream_state_e;

  function automatic int calc_measurement_rounds(input int dist_x, input int dist_z);
    return (dist_x > dist_z) ? dist_x : dist_z;
  endfunction

  function automatic int calc_pu_count(input int dist_x, input int dist_z);
    return dist_x * dist_z * calc_measurement_rounds(dist_x, dist_z);
  endfunction

  // Each root address holds one coordinate per axis of the 3-D grid.
  function automatic int calc_address_width(input int dist_x, input int dist_z);
    return 3 * $clog2(calc_measurement_rounds(dist_x, dist_z));
  endfunction

  function automatic logic [OUT_WIDTH-1:0] pack_hdr1(input logic [7:0] iter,
                                                     input logic       dead,
                                                     input logic       fcard,
                                                     input logic [7:0] drops);
    logic [OUT_WIDTH-1:0] word;
    word = '0;
    word[HDR1_ITER_LSB +: 8]      = iter;
    word[HDR1_DEADLOCK_BIT]       = dead;
    word[HDR1_FINAL_CARD_BIT]     = fcard;
    word[HDR1_DROP_LSB +: 8]      = drops;
    return word;
  endfunction

endpackage

// File: rtl/decoder_result_streamer_snapshot_reg.sv
// result_snapshot_reg: rising-edge detect on the decoder's result_valid level
// and a capture-enabled register bank holding one decoder result. The bank
// only loads while load_en is high so an in-flight frame is never disturbed.
module result_snapshot_reg #(
  parameter int ROOTS_WIDTH = 900
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   result_valid,
  input  logic                   load_en,
  input  logic [ROOTS_WIDTH-1:0] roots,
  input  logic [7:0]             iteration_counter,
  input  logic [31:0]            cycle_counter,
  input  logic                   deadlock,
  input  logic                   final_cardinality,
  output logic                   capture,
  output logic [ROOTS_WIDTH-1:0] roots_snap,
  output logic [7:0]             iter_snap,
  output logic [31:0]            cycles_snap,
  output logic                   deadlock_snap,
  output logic                   final_card_snap
);

  logic result_valid_q;

  // A held result level produces exactly one capture pulse.
  assign capture = result_valid & ~result_valid_q;

  // Edge-detect history plus snapshot bank, loaded only on an accepted capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      result_valid_q  <= 1'b0;
      roots_snap      <= '0;
      iter_snap       <= '0;
      cycles_snap     <= '0;
      deadlock_snap   <= 1'b0;
      final_card_snap <= 1'b0;
    end else begin
      result_valid_q <= result_valid;
      if (capture && load_en) begin
        roots_snap      <= roots;
        iter_snap       <= iteration_counter;
        cycles_snap     <= cycle_counter;
        deadlock_snap   <= deadlock;
        final_card_snap <= final_cardinality;
      end
    end
  end

endmodule

// File: rtl/decoder_result_streamer.sv
// decoder_result_streamer: snapshots each new decoder result and streams it
// as 32-bit beats (HDR0, HDR1, one ROOTS beat per PU) over valid/ready/last.
// Results arriving while a frame is in flight are counted in drop_count.
// Optional build macro RESULT_STREAM_CHECKSUM_EN appends a TRL beat carrying
// the XOR of every earlier beat of the frame; out_last then moves to TRL.
module decoder_result_streamer
  import decoder_result_streamer_pkg::*;
#(
  parameter  int CODE_DISTANCE_X    = 5,
  parameter  int CODE_DISTANCE_Z    = 4,
  localparam int MEASUREMENT_ROUNDS = calc_measurement_rounds(CODE_DISTANCE_X, CODE_DISTANCE_Z),
  localparam int PU_COUNT           = calc_pu_count(CODE_DISTANCE_X, CODE_DISTANCE_Z),
  localparam int ADDRESS_WIDTH      = calc_address_width(CODE_DISTANCE_X, CODE_DISTANCE_Z)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              result_valid,
  input  logic [ADDRESS_WIDTH*PU_COUNT-1:0] roots,
  input  logic [7:0]                        iteration_counter,
  input  logic [31:0]                       cycle_counter,
  input  logic                              deadlock,
  input  logic                              final_cardinality,
  output logic [OUT_WIDTH-1:0]              out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              busy,
  output logic [7:0]                        drop_count
);

  localparam int IDX_W = $clog2(PU_COUNT + 1);

  // Root beats carry a 16-bit index and a zero-extended address.
  if (ADDRESS_WIDTH > 16 || PU_COUNT > 65535) begin : g_width_check
    $error("decoder_result_streamer: ADDRESS_WIDTH must be <= 16 and PU_COUNT <= 65535");
  end

  stream_state_e              state_reg, state_next;
  logic [IDX_W-1:0]           idx_reg, idx_next;
  logic [7:0]                 drop_count_reg, drop_count_next;
  logic [7:0]                 hdr_drop_reg, hdr_drop_next;
  logic                       xfer;
  logic                       last_root;

  logic                              capture;
  logic [ADDRESS_WIDTH*PU_COUNT-1:0] roots_snap;
  logic [7:0]                        iter_snap;
  logic [31:0]                       cycles_snap;
  logic                              deadlock_snap;
  logic                              final_card_snap;

  result_snapshot_reg #(
    .ROOTS_WIDTH(ADDRESS_WIDTH*PU_COUNT)
  ) u_snapshot (
    .clk              (clk),
    .reset            (reset),
    .result_valid     (result_valid),
    .load_en          (state_reg == ST_IDLE),
    .roots            (roots),
    .iteration_counter(iteration_counter),
    .cycle_counter    (cycle_counter),
    .deadlock         (deadlock),
    .final_cardinality(final_cardinality),
    .capture          (capture),
    .roots_snap       (roots_snap),
    .iter_snap        (iter_snap),
    .cycles_snap      (cycles_snap),
    .deadlock_snap    (deadlock_snap),
    .final_card_snap  (final_card_snap)
  );

  // Unpack the flat snapshot into per-PU root addresses for the beat mux.
  logic [ADDRESS_WIDTH-1:0] root_array [PU_COUNT];
  for (genvar gi = 0; gi < PU_COUNT; gi++) begin : g_root_unpack
    assign root_array[gi] = roots_snap[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  end

  assign last_root  = (idx_reg == IDX_W'(PU_COUNT - 1));
  assign xfer       = out_valid & out_ready;
  assign busy       = out_valid;
  assign drop_count = drop_count_reg;

`ifdef RESULT_STREAM_CHECKSUM_EN
  logic [OUT_WIDTH-1:0] csum_reg;

  // Running XOR of transferred beats; restarts when a new frame is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      csum_reg <= '0;
    end else if (capture && state_reg == ST_IDLE) begin
      csum_reg <= '0;
    end else if (xfer) begin
      csum_reg <= csum_reg ^ out_data;
    end
  end
`endif

  // Results that arrive with a frame in flight are lost; count them, saturating.
  always_comb begin
    drop_count_next = drop_count_reg;
    if (capture && state_reg != ST_IDLE && drop_count_reg != 8'hFF) begin
      drop_count_next = drop_count_reg + 8'd1;
    end
  end

  // Next-state, beat mux and framing; the state only advances on a transfer so
  // data and last hold steady under backpressure.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    hdr_drop_next = hdr_drop_reg;
    out_valid     = (state_reg != ST_IDLE);
    out_data      = '0;
    out_last      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (capture) begin
          state_next = ST_HDR0;
        end
      end
      ST_HDR0: begin
        out_data = cycles_snap;
        if (xfer) begin
          state_next    = ST_HDR1;
          // Freeze the drop count as it stands when HDR1 is first presented.
          hdr_drop_next = drop_count_next;
        end
      end
      ST_HDR1: begin
        out_data = pack_hdr1(iter_snap, deadlock_snap, final_card_snap, hdr_drop_reg);
        if (xfer) begin
          state_next = ST_ROOTS;
          idx_next   = '0;
        end
      end
      ST_ROOTS: begin
        out_data = {16'(idx_reg), 16'(root_array[idx_reg])};
`ifndef RESULT_STREAM_CHECKSUM_EN
        out_last = last_root;
`endif
        if (xfer) begin
          if (last_root) begin
            idx_next = '0;
`ifdef RESULT_STREAM_CHECKSUM_EN
            state_next = ST_TRL;
`else
            state_next = ST_IDLE;
`endif
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
`ifdef RESULT_STREAM_CHECKSUM_EN
      ST_TRL: begin
        out_data = csum_reg;
        out_last = 1'b1;
        if (xfer) begin
          state_next = ST_IDLE;
        end
      end
`endif
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, index and counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      drop_count_reg <= '0;
      hdr_drop_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      drop_count_reg <= drop_count_next;
      hdr_drop_reg   <= hdr_drop_next;
    end
  end

endmodule

// File: tb/tb_decoder_result_streamer.sv
// Scoreboard bench for decoder_result_streamer: stimulus pushes the expected
// beat sequence of each frame, a negedge monitor pops and compares every
// transferred beat and checks stability under backpressure.
module tb_decoder_result_streamer;
  import decoder_result_streamer_pkg::*;

  localparam int PU = 100;
  localparam int AW = 9;
`ifdef RESULT_STREAM_CHECKSUM_EN
  localparam int FRAME_LEN = PU + 3;
`else
  localparam int FRAME_LEN = PU + 2;
`endif

  logic             clk;
  logic             reset;
  logic             result_valid;
  logic [AW*PU-1:0] roots;
  logic [7:0]       iteration_counter;
  logic [31:0]      cycle_counter;
  logic             deadlock;
  logic             final_cardinality;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic [7:0]       drop_count;

  decoder_result_streamer dut (
    .clk              (clk),
    .reset            (reset),
    .result_valid     (result_valid),
    .roots            (roots),
    .iteration_counter(iteration_counter),
    .cycle_counter    (cycle_counter),
    .deadlock         (deadlock),
    .final_cardinality(final_cardinality),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last),
    .busy             (busy),
    .drop_count       (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    checks      = 0;
  int    failures    = 0;
  int    frame_beat  = 0;
  int    frames_done = 0;

  function automatic logic [8:0] root_val(input int sel, input int i);
    case (sel)
      0:       return 9'(i % 512);
      1:       return 9'((3 * i + 1) % 512);
      2:       return 9'd0;
      default: return 9'(511 - i);
    endcase
  endfunction

  task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  task automatic load_inputs(input logic [31:0] cc, input logic [7:0] iter, input logic dl,
                             input logic fc, input int sel);
    cycle_counter     = cc;
    iteration_counter = iter;
    deadlock          = dl;
    final_cardinality = fc;
    for (int i = 0; i < PU; i++) roots[i*AW +: AW] = root_val(sel, i);
  endtask

  // Expected frame built from the field layout of each beat.
  task automatic push_frame(input logic [31:0] cc, input logic [7:0] iter, input logic dl,
                            input logic fc, input int sel, input logic [7:0] drops);
    beat_t       b;
    logic [31:0] acc;
    acc = 32'h0;
    b.data = cc; b.last = 1'b0; exp_q.push_back(b); acc ^= b.data;
    b.data = {iter, dl, fc, 6'b000000, drops, 8'h00}; exp_q.push_back(b); acc ^= b.data;
    for (int i = 0; i < PU; i++) begin
      b.data = {16'(i), 7'b0000000, root_val(sel, i)};
`ifdef RESULT_STREAM_CHECKSUM_EN
      b.last = 1'b0;
`else
      b.last = (i == PU - 1);
`endif
      exp_q.push_back(b);
      acc ^= b.data;
    end
`ifdef RESULT_STREAM_CHECKSUM_EN
    b.data = acc; b.last = 1'b1; exp_q.push_back(b);
`endif
  endtask

  task automatic pulse_valid();
    @(posedge clk); #1 result_valid = 1'b1;
    @(posedge clk); #1 result_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [31:0] cc, input logic [7:0] iter, input logic dl,
                             input logic fc, input int sel, input logic [7:0] drops);
    load_inputs(cc, iter, dl, fc, sel);
    push_frame(cc, iter, dl, fc, sel, drops);
    pulse_valid();
  endtask

  task automatic wait_frames(input string name, input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (frames_done < target) begin
      failures++;
      $display("FAIL %s timeout frames=%0d required=%0d", name, frames_done, target);
    end
  endtask

  task automatic wait_beat(input string name, input int b);
    int n = 0;
    while (frame_beat < b && n < 500) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (frame_beat < b) begin
      failures++;
      $display("FAIL %s timeout beat=%0d required=%0d", name, frame_beat, b);
    end
  endtask

  // Monitor: compare each transferred beat, check hold under stall and idle after last.
  initial begin
    logic        prev_stall = 1'b0;
    logic        idle_chk   = 1'b0;
    logic [31:0] prev_data  = 32'h0;
    logic        prev_last  = 1'b0;
    beat_t       e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        frame_beat = 0;
        prev_stall = 1'b0;
        idle_chk   = 1'b0;
      end else begin
        if (idle_chk) begin
          checks++;
          if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_last valid=%b busy=%b required valid=0 busy=0", out_valid, busy);
          end
          idle_chk = 1'b0;
        end
        if (prev_stall) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
            failures++;
            $display("FAIL stall_hold valid=%b data=0x%08h last=%b required valid=1 data=0x%08h last=%b",
                     out_valid, out_data, out_last, prev_data, prev_last);
          end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat data=0x%08h last=%b required no beat", out_data, out_last);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e.data || out_last !== e.last) begin
              failures++;
              $display("FAIL beat%0d data=0x%08h last=%b required data=0x%08h last=%b",
                       frame_beat, out_data, out_last, e.data, e.last);
            end
          end
          frame_beat++;
          if (out_last === 1'b1) begin
            frames_done++;
            frame_beat = 0;
            idle_chk   = 1'b1;
          end
          prev_stall = 1'b0;
        end else begin
          prev_stall = (out_valid === 1'b1);
        end
        prev_data = out_data;
        prev_last = out_last;
      end
    end
  end

  // Stimulus.
  initial begin
    int  target;
    int  n;
    bit  stalled;
    reset        = 1'b0;
    result_valid = 1'b0;
    out_ready    = 1'b1;
    load_inputs(32'h0, 8'h0, 1'b0, 1'b0, 2);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_val("reset_out_valid", 32'(out_valid), 32'h0);
    check_val("reset_out_last", 32'(out_last), 32'h0);
    check_val("reset_out_data", out_data, 32'h0);
    check_val("reset_busy", 32'(busy), 32'h0);
    check_val("reset_drop_count", 32'(drop_count), 32'h0);

    // Single frame at full rate: must finish in exactly FRAME_LEN cycles.
    $display("txn single_frame cc=0x00000123 iter=7 dl=0 fc=1");
    target = frames_done + 1;
    start_frame(32'h0000_0123, 8'd7, 1'b0, 1'b1, 0, 8'd0);
    repeat (FRAME_LEN) @(negedge clk);
    #1 check_val("no_bubble_frames", 32'(frames_done), 32'(target));
    wait_frames("single_frame", target, 20);
    @(negedge clk);
    check_val("single_busy_after", 32'(busy), 32'h0);

    // Backpressure: alternate ready, plus a 20-cycle stall at beat 50.
    $display("txn backpressure cc=0x5A5A0042 iter=200 dl=1 fc=0");
    target = frames_done + 1;
    start_frame(32'h5A5A_0042, 8'd200, 1'b1, 1'b0, 1, 8'd0);
    stalled = 1'b0;
    n = 0;
    while (frames_done < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (!stalled && frame_beat >= 50) begin
        out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1 stalled = 1'b1;
      end else begin
        out_ready = ~out_ready;
      end
    end
    out_ready = 1'b1;
    wait_frames("backpressure", target, 10);
    check_val("backpressure_stalled", 32'(stalled), 32'h1);

    // Level held for 300 cycles: one frame, no drops.
    $display("txn level_hold cc=0x00C0FFEE iter=1");
    target = frames_done + 1;
    load_inputs(32'h00C0_FFEE, 8'd1, 1'b0, 1'b0, 3);
    push_frame(32'h00C0_FFEE, 8'd1, 1'b0, 1'b0, 3, 8'd0);
    @(posedge clk); #1 result_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1 result_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 check_val("level_hold_frames", 32'(frames_done), 32'(target));
    check_val("level_hold_drops", 32'(drop_count), 32'h0);
    check_val("level_hold_queue", 32'(exp_q.size()), 32'h0);

    // Two captures while busy: frame unchanged, drop_count=2.
    $display("txn drop_while_busy cc=0xAAAA0001 iter=3 dl=1 fc=0");
    target = frames_done + 1;
    start_frame(32'hAAAA_0001, 8'd3, 1'b1, 1'b0, 3, 8'd0);
    wait_beat("drop_beat10", 10);
    load_inputs(32'h1111_1111, 8'd99, 1'b0, 1'b1, 0);
    pulse_valid();
    wait_beat("drop_beat40", 40);
    load_inputs(32'h2222_2222, 8'd55, 1'b1, 1'b1, 1);
    pulse_valid();
    wait_frames("drop_frame", target, 200);
    @(negedge clk);
    check_val("drop_count_two", 32'(drop_count), 32'h2);

    $display("txn post_drop_frame cc=0x0000BEEF iter=9 drops=2");
    target = frames_done + 1;
    start_frame(32'h0000_BEEF, 8'd9, 1'b0, 1'b0, 0, 8'd2);
    wait_frames("post_drop_frame", target, 200);

    // Reset for one cycle at beat 60 aborts the frame.
    $display("txn reset_mid_frame cc=0x0BAD0060");
    start_frame(32'h0BAD_0060, 8'd4, 1'b0, 1'b1, 1, 8'd2);
    wait_beat("reset_beat60", 60);
    @(posedge clk); #1 reset = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1 exp_q.delete(); reset = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check_val("abort_out_valid", 32'(out_valid), 32'h0);
    check_val("abort_busy", 32'(busy), 32'h0);
    check_val("abort_drop_count", 32'(drop_count), 32'h0);

    $display("txn fresh_after_reset cc=0x00000777 iter=12");
    target = frames_done + 1;
    start_frame(32'h0000_0777, 8'd12, 1'b1, 1'b1, 0, 8'd0);
    wait_frames("fresh_after_reset", target, 200);

    // Zero roots with a high cycle count (checksum trailer when enabled).
    $display("txn zero_roots cc=0xFFFF0000");
    target = frames_done + 1;
    start_frame(32'hFFFF_0000, 8'd0, 1'b0, 1'b0, 2, 8'd0);
    wait_frames("zero_roots", target, 200);
    repeat (2) @(negedge clk);
    check_val("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "global timeout");
  end

endmodule
